iot_in_ctrl: RTL and testbench

- Front-end controller for the IoT data-filtering datapath.
- Assembles the serial byte stream (iot_in) into 128-bit words and produces the shared control bus consumed directly downstream by every filter stage, including the max filter (fn_sel 3'b110): data, cnt, state, valid, flag, cycle_cnt.
- Sequences words into rounds and rounds into a complete job, then signals done.

---
 rtl/iot_in_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_iot_in_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/iot_in_ctrl.sv
// Front-end controller: packs the serial byte stream into 128-bit words and sequences words/rounds/job.
// Optional build macro IOT_TIMEOUT_EN adds an idle timeout that discards a stalled partial word.
module iot_in_ctrl #(
   parameter int WORDS_PER_ROUND = 8,
   parameter int NUM_ROUNDS      = 4,
   parameter int TIMEOUT         = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   iot_in,
   input  logic         in_en,
   input  logic [2:0]   fn_sel_in,
   output logic         busy,
   output logic [127:0] data,
   output logic [5:0]   cnt,
   output logic [2:0]   state,
   output logic         valid,
   output logic         flag,
   output logic [7:0]   cycle_cnt,
   output logic [2:0]   fn_sel,
   output logic         done,
   output logic         err
);

   localparam logic [2:0] ST_IDLE = 3'b000;
   localparam logic [2:0] ST_LOAD = 3'b001;
   localparam logic [2:0] ST_EVAL = 3'b010;
   localparam logic [2:0] ST_NEXT = 3'b011;
   localparam logic [2:0] ST_DONE = 3'b100;

   localparam logic [7:0] LAST_WORD  = 8'(WORDS_PER_ROUND - 1);
   localparam logic [7:0] LAST_ROUND = 8'(NUM_ROUNDS - 1);

   if (WORDS_PER_ROUND < 1 || WORDS_PER_ROUND > 255 || NUM_ROUNDS < 1 || NUM_ROUNDS > 255 ||
       TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
      $error("iot_in_ctrl: parameter out of legal range 1..255");
   end

   logic [2:0]   state_q, state_d;
   logic [127:0] data_q, data_d;
   logic [5:0]   cnt_q, cnt_d;
   logic         valid_q, valid_d;
   logic         flag_q, flag_d;
   logic [7:0]   cyc_q, cyc_d;
   logic [7:0]   round_q, round_d;
   logic [2:0]   fn_sel_q, fn_sel_d;
   logic         done_q, done_d;
   logic [127:0] data_shift;

   assign data_shift = {data_q[119:0], iot_in};

`ifdef IOT_TIMEOUT_EN
   localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);
   logic [7:0] idle_q, idle_d;
   logic       err_q, err_d;
`endif

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      flag_d   = flag_q;
      cyc_d    = cyc_q;
      round_d  = round_q;
      fn_sel_d = fn_sel_q;
      done_d   = done_q;
`ifdef IOT_TIMEOUT_EN
      idle_d   = idle_q;
      err_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_en) begin
               fn_sel_d = fn_sel_in;
               data_d   = data_shift;
               cnt_d    = 6'd1;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_en) begin
               data_d = data_shift;
               cnt_d  = cnt_q + 6'd1;
`ifdef IOT_TIMEOUT_EN
               idle_d = 8'd0;
`endif
               if (cnt_q == 6'd15) begin
                  state_d = ST_EVAL;
                  valid_d = 1'b1;
               end
`ifdef IOT_TIMEOUT_EN
            end else if (cnt_q != 6'd0) begin
               // A stalled partial word is thrown away; round position is kept.
               if (idle_q == IDLE_LAST) begin
                  idle_d = 8'd0;
                  cnt_d  = 6'd0;
                  data_d = '0;
                  err_d  = 1'b1;
               end else begin
                  idle_d = idle_q + 8'd1;
               end
`endif
            end
         end
         ST_EVAL: begin
            cnt_d   = 6'd0;
            valid_d = 1'b0;
            if (cyc_q == LAST_WORD) begin
               state_d = ST_NEXT;
            end else begin
               cyc_d   = cyc_q + 8'd1;
               state_d = ST_LOAD;
            end
         end
         ST_NEXT: begin
            cyc_d  = 8'd0;
            flag_d = 1'b1;
            if (round_q == LAST_ROUND) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               round_d = round_q + 8'd1;
               state_d = ST_LOAD;
            end
         end
         ST_DONE: ;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         cnt_q    <= 6'd0;
         valid_q  <= 1'b0;
         flag_q   <= 1'b0;
         cyc_q    <= 8'd0;
         round_q  <= 8'd0;
         fn_sel_q <= 3'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         flag_q   <= flag_d;
         cyc_q    <= cyc_d;
         round_q  <= round_d;
         fn_sel_q <= fn_sel_d;
         done_q   <= done_d;
      end
   end

`ifdef IOT_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         idle_q <= 8'd0;
         err_q  <= 1'b0;
      end else begin
         idle_q <= idle_d;
         err_q  <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Held busy while in reset so upstream never sees an accept window mid-reset.
   assign busy      = !rst || !(state_q == ST_IDLE || state_q == ST_LOAD);
   assign data      = data_q;
   assign cnt       = cnt_q;
   assign state     = state_q;
   assign valid     = valid_q;
   assign flag      = flag_q;
   assign cycle_cnt = cyc_q;
   assign fn_sel    = fn_sel_q;
   assign done      = done_q;

endmodule

// File: tb/tb_iot_in_ctrl.sv
// Bench for iot_in_ctrl: word/round-level model compared every cycle plus directed literal checks.
module tb_iot_in_ctrl;
   localparam int W = 2;
   localparam int R = 2;

   logic         clk = 1'b0;
   logic         rst, in_en;
   logic [7:0]   iot_in;
   logic [2:0]   fn_sel_in;
   logic         busy, valid, flag, done, err;
   logic [127:0] data;
   logic [5:0]   cnt;
   logic [2:0]   state, fn_sel;
   logic [7:0]   cycle_cnt;

   always #5 clk = ~clk;

   iot_in_ctrl #(.WORDS_PER_ROUND(W), .NUM_ROUNDS(R), .TIMEOUT(32)) dut (
      .clk(clk), .rst(rst), .iot_in(iot_in), .in_en(in_en), .fn_sel_in(fn_sel_in),
      .busy(busy), .data(data), .cnt(cnt), .state(state), .valid(valid), .flag(flag),
      .cycle_cnt(cycle_cnt), .fn_sel(fn_sel), .done(done), .err(err)
   );

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // Model: bytes accepted into the current word, words finished in the job,
   // and remaining busy cycles after a word (1 = EVAL only, 2 = EVAL+NEXT).
   bit           m_started;
   int           m_nb, m_nw, m_g, m_gtot;
   logic [127:0] m_data;
   logic [2:0]   m_fn;

   function automatic bit m_done();
      return m_nw == W * R && m_g == 0;
   endfunction

   function automatic bit m_busy();
      return m_started && (m_g > 0 || m_done());
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m_started = 0; m_nb = 0; m_nw = 0; m_g = 0; m_gtot = 1;
         m_data = '0; m_fn = 3'd0;
      end else if (in_en && !m_busy()) begin
         if (!m_started) begin
            m_started = 1;
            m_fn = fn_sel_in;
         end
         m_data = {m_data[119:0], iot_in};
         m_nb++;
         if (m_nb == 16) begin
            m_nb = 0;
            m_nw++;
            m_gtot = (m_nw % W == 0) ? 2 : 1;
            m_g = m_gtot;
         end
      end else if (m_g > 0) begin
         m_g--;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit ev, nx;
         logic [2:0] es;
         ev = m_g > 0 && m_g == m_gtot;
         nx = m_gtot == 2 && m_g == 1;
         es = !m_started ? 3'd0 : m_done() ? 3'd4 : ev ? 3'd2 : nx ? 3'd3 : 3'd1;
         chk("m_state", 128'(state), 128'(es));
         chk("m_busy", 128'(busy), 128'(!rst || m_busy()));
         chk("m_valid", 128'(valid), 128'(ev));
         chk("m_cnt", 128'(cnt), ev ? 128'd16 : 128'(m_nb));
         chk("m_data", data, m_data);
         chk("m_cycle_cnt", 128'(cycle_cnt), m_g > 0 ? 128'((m_nw - 1) % W) : 128'(m_nw % W));
         chk("m_flag", 128'(flag), m_g > 0 ? 128'((m_nw - 1) / W > 0) : 128'(m_nw / W > 0));
         chk("m_fn_sel", 128'(fn_sel), 128'(m_fn));
         chk("m_done", 128'(done), 128'(m_done()));
         chk("m_err", 128'(err), 128'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] wd [3];
      logic [7:0]   wc [3];
      logic         wf [3];
      int           nv;
      logic [7:0]   bc;

      rst = 1'b0; in_en = 1'b0; iot_in = 8'h00; fn_sel_in = 3'd0;
      for (int i = 0; i < 2; i++) begin
         in_en = 1'($urandom_range(0, 1));
         iot_in = 8'($urandom);
         @(posedge clk);
         #1 chk_en = 1'b1;
      end
      @(negedge clk);
      chk("rst_state", 128'(state), 128'd0);
      chk("rst_cnt", 128'(cnt), 128'd0);
      chk("rst_data", data, 128'd0);
      chk("rst_valid", 128'(valid), 128'd0);
      chk("rst_flag", 128'(flag), 128'd0);
      chk("rst_busy", 128'(busy), 128'd1);
      chk("rst_done", 128'(done), 128'd0);

      // Word 0: bytes 00..0F with max-filter select.
      rst = 1'b1; fn_sel_in = 3'b110;
      for (int i = 0; i < 16; i++) begin
         in_en = 1'b1; iot_in = 8'(i);
         @(negedge clk);
      end
      in_en = 1'b0; fn_sel_in = 3'b000;
      chk("w0_data", data, 128'h000102030405060708090A0B0C0D0E0F);
      chk("w0_cnt", 128'(cnt), 128'd16);
      chk("w0_state", 128'(state), 128'd2);
      chk("w0_valid", 128'(valid), 128'd1);
      chk("w0_fn_sel", 128'(fn_sel), 128'd6);
      chk("w0_cycle_cnt", 128'(cycle_cnt), 128'd0);
      chk("w0_flag", 128'(flag), 128'd0);
      @(negedge clk);
      chk("w0_after_cnt", 128'(cnt), 128'd0);
      chk("w0_after_state", 128'(state), 128'd1);

      // Continuous in_en: bytes offered during EVAL/NEXT must be dropped.
      nv = 0; bc = 8'h20;
      for (int k = 0; k < 100 && !done; k++) begin
         in_en = 1'b1; iot_in = bc; bc++;
         @(negedge clk);
         if (valid && nv < 3) begin
            wd[nv] = data; wc[nv] = cycle_cnt; wf[nv] = flag; nv++;
         end
      end
      in_en = 1'b0;
      chk("stream_words", 128'(nv), 128'd3);
      if (nv == 3) begin
         chk("w1_data", wd[0], 128'h202122232425262728292A2B2C2D2E2F);
         chk("w1_cyc", 128'(wc[0]), 128'd1);
         chk("w1_flag", 128'(wf[0]), 128'd0);
         chk("w2_data", wd[1], 128'h32333435363738393A3B3C3D3E3F4041);
         chk("w2_cyc", 128'(wc[1]), 128'd0);
         chk("w2_flag", 128'(wf[1]), 128'd1);
         chk("w3_data", wd[2], 128'h434445464748494A4B4C4D4E4F505152);
         chk("w3_cyc", 128'(wc[2]), 128'd1);
         chk("w3_flag", 128'(wf[2]), 128'd1);
      end
      @(negedge clk);
      chk("job_done", 128'(done), 128'd1);
      chk("job_state", 128'(state), 128'd4);

      // Mid-word reset discards the partial word.
      rst = 1'b0; fn_sel_in = 3'b011;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_en = 1'b1; iot_in = 8'(8'h11 + i);
         @(negedge clk);
      end
      in_en = 1'b0; rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_en = 1'b1; iot_in = 8'hFF;
         @(negedge clk);
      end
      in_en = 1'b0;
      chk("mr_data", data, {128{1'b1}});
      chk("mr_cycle_cnt", 128'(cycle_cnt), 128'd0);
      chk("mr_flag", 128'(flag), 128'd0);
      chk("mr_valid", 128'(valid), 128'd1);
      chk("mr_fn_sel", 128'(fn_sel), 128'd3);
      @(negedge clk);

`ifdef IOT_TIMEOUT_EN
      begin
         int n;
         chk_en = 1'b0;
         rst = 1'b0;
         @(negedge clk);
         rst = 1'b1;
         for (int i = 0; i < 5; i++) begin
            in_en = 1'b1; iot_in = 8'(8'h50 + i);
            @(negedge clk);
         end
         in_en = 1'b0;
         n = 0;
         while (n < 40 && !err) begin
            @(negedge clk);
            n++;
         end
         chk("to_cycles", 128'(n), 128'd32);
         chk("to_err", 128'(err), 128'd1);
         chk("to_cnt", 128'(cnt), 128'd0);
         chk("to_data", data, 128'd0);
         chk("to_state", 128'(state), 128'd1);
         @(negedge clk);
         chk("to_err_pulse", 128'(err), 128'd0);
         for (int i = 0; i < 16; i++) begin
            in_en = 1'b1; iot_in = 8'(8'hA0 + i);
            @(negedge clk);
         end
         in_en = 1'b0;
         chk("to_w_data", data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
         chk("to_w_cyc", 128'(cycle_cnt), 128'd0);
         chk("to_w_state", 128'(state), 128'd2);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
